// File: rtl/array_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : array_bus_pkg
//  Description : Definitions shared by the two-lane array-bus stages: the
//                lane count, the default lane data width, and the lane index
//                and data word types.
//  Revision    : 1.0  initial release
// ============================================================================
package array_bus_pkg;

    localparam int NUM_LANES      = 2;
    localparam int DATA_W_DEFAULT = 8;

    // With two lanes, a lane index is a single bit.
    typedef logic                      lane_t;
    typedef logic [DATA_W_DEFAULT-1:0] word_t;

endpackage
`default_nettype wire

// File: rtl/array_bus_lane_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : array_bus_lane_fifo
//  Description : Single-lane FIFO with DEPTH entries. The head word is
//                visible on rd_data without a read cycle (show-ahead).
//                Push and pop may happen in the same cycle, including when
//                the FIFO is full. The caller must not push a full FIFO
//                unless it pops in the same cycle, and must never pop an
//                empty FIFO.
//  Ports       : clk, rst_n        clock, asynchronous active-low reset
//                push, wr_data     write strobe and data
//                pop               remove the head word
//                rd_data           head word (valid while !empty)
//                full, empty       occupancy flags
//  Revision    : 1.0  initial release
// ============================================================================
module array_bus_lane_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = $clog2(DEPTH + 1);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    // Storage is not reset: the pointers and the count define which entries
    // are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the address pointers wrap modulo DEPTH
    // by natural overflow. The separate occupancy count (0..DEPTH) tells
    // full from empty when the two pointers are equal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign full    = (r_count == c_CNT_W'(DEPTH));
    assign empty   = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/array_bus_merge.sv
`default_nettype none
// ============================================================================
//  Module      : array_bus_merge
//  Description : Merges the two lanes of a registered array bus into one
//                word stream. Each lane is buffered in its own FIFO, and a
//                round-robin arbiter feeds a single output register that
//                supports valid/ready handshaking. A word that reaches a
//                full FIFO which is not popped in the same cycle is dropped,
//                and that lane's sticky overflow flag is set.
//  Ports       : clk, rst_n              clock, asynchronous active-low reset
//                in_data[0:1]            per-lane input data
//                in_valid[0:1]           per-lane input valid (no backpressure)
//                out_data/out_lane       merged word and its source lane
//                out_valid/out_ready     output handshake
//                overflow[0:1]           sticky per-lane drop flags
//                delivered_cnt[0:1]      per-lane handshake counters; present
//                                        only when ARRAY_BUS_MERGE_STATS_EN
//                                        is defined
//  Config      : `define ARRAY_BUS_MERGE_STATS_EN enables delivered_cnt
//  Revision    : 1.0  initial release
// ============================================================================
module array_bus_merge
    import array_bus_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data  [0:NUM_LANES-1],
    input  logic              in_valid [0:NUM_LANES-1],
    output logic [DATA_W-1:0] out_data,
    output logic              out_lane,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef ARRAY_BUS_MERGE_STATS_EN
    output logic [15:0]       delivered_cnt [0:NUM_LANES-1],
`endif
    output logic              overflow [0:NUM_LANES-1]
);

    logic [NUM_LANES-1:0] w_full;
    logic [NUM_LANES-1:0] w_empty;
    logic [NUM_LANES-1:0] w_pop;
    logic [DATA_W-1:0]    w_rd_data [NUM_LANES];

    logic                 w_load;
    logic                 w_grant_valid;
    lane_t                w_grant;

    logic                 r_out_valid;
    logic [DATA_W-1:0]    r_out_data;
    lane_t                r_out_lane;
    lane_t                r_rr_ptr;

    // The output register can take a new word when it is empty, or when its
    // current word is accepted in this cycle.
    assign w_load = !r_out_valid || out_ready;

    always_comb begin
        w_grant_valid = !w_empty[0] || !w_empty[1];
        w_grant       = 1'b0;
        if (!w_empty[0] && !w_empty[1]) begin
            w_grant = r_rr_ptr;
        end else if (w_empty[0]) begin
            w_grant = 1'b1;
        end
        w_pop    = '0;
        if (w_load && w_grant_valid) begin
            w_pop[w_grant] = 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic w_push;
        logic r_ovf;

        // A full FIFO can still take the arriving word if the arbiter pops
        // it in the same cycle.
        assign w_push = in_valid[i] && (!w_full[i] || w_pop[i]);

        array_bus_lane_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push    (w_push),
            .wr_data (in_data[i]),
            .pop     (w_pop[i]),
            .rd_data (w_rd_data[i]),
            .full    (w_full[i]),
            .empty   (w_empty[i])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ovf <= 1'b0;
            end else if (in_valid[i] && !w_push) begin
                r_ovf <= 1'b1;
            end
        end

        assign overflow[i] = r_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_lane  <= 1'b0;
            r_rr_ptr    <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= w_grant_valid;
            if (w_grant_valid) begin
                r_out_data <= w_rd_data[w_grant];
                r_out_lane <= w_grant;
                r_rr_ptr   <= ~w_grant;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_lane  = r_out_lane;

`ifdef ARRAY_BUS_MERGE_STATS_EN
    logic [15:0] r_delivered_cnt [NUM_LANES];

    // Counters wrap naturally from 0xFFFF to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                r_delivered_cnt[k] <= '0;
            end
        end else if (r_out_valid && out_ready) begin
            r_delivered_cnt[r_out_lane] <= r_delivered_cnt[r_out_lane] + 16'd1;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_stats
        assign delivered_cnt[i] = r_delivered_cnt[i];
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_array_bus_merge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_array_bus_merge
//  Description : Directed self-checking bench for array_bus_merge with
//                DATA_W=8 and DEPTH=4. Inputs are driven 1 time unit after
//                the rising edge, and registered outputs are checked at the
//                same point.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_array_bus_merge;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data  [0:1];
    logic          in_valid [0:1];
    logic [DW-1:0] out_data;
    logic          out_lane;
    logic          out_valid;
    logic          out_ready;
    logic          overflow [0:1];
`ifdef ARRAY_BUS_MERGE_STATS_EN
    logic [15:0]   delivered_cnt [0:1];
`endif

    int checks = 0;
    int errors = 0;

    array_bus_merge #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .out_data      (out_data),
        .out_lane      (out_lane),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
`ifdef ARRAY_BUS_MERGE_STATS_EN
        .delivered_cnt (delivered_cnt),
`endif
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        in_data[0]  = '0;
        in_data[1]  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_con [8];
        exp_con = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        idle_inputs();
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data), 0);
        chk("rst_out_lane",  32'(out_lane), 0);
        chk("rst_ovf0",      32'(overflow[0]), 0);
        chk("rst_ovf1",      32'(overflow[1]), 0);
        rst_n = 1'b1;
        tick();

        // ---------------- single word, 2-cycle latency ----------------
        out_ready   = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h5A;
        tick();
        idle_inputs();
        chk("single_n1_valid", 32'(out_valid), 0);
        tick();
        chk("single_n2_valid", 32'(out_valid), 1);
        chk("single_n2_data",  32'(out_data), 32'h5A);
        chk("single_n2_lane",  32'(out_lane), 0);
        tick();
        chk("single_n3_valid", 32'(out_valid), 0);

        // ---------------- contention, round-robin ----------------
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid[0] = (k < 4);
            in_valid[1] = (k < 4);
            in_data[0]  = 8'(8'h10 + k);
            in_data[1]  = 8'(8'h20 + k);
            tick();
            if (k >= 1 && k <= 8) begin
                chk("con_valid", 32'(out_valid), 1);
                chk("con_data",  32'(out_data), 32'(exp_con[k-1]));
                chk("con_lane",  32'(out_lane), 32'((k - 1) % 2));
            end
            if (k == 9) begin
                chk("con_end_valid", 32'(out_valid), 0);
            end
        end
        chk("con_ovf0", 32'(overflow[0]), 0);
        chk("con_ovf1", 32'(overflow[1]), 0);

        // ---------------- backpressure and overflow ----------------
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 8'(k + 1);
            tick();
            if (k == 2) begin
                chk("bp_hold_data", 32'(out_data), 32'h01);
            end
            if (k == 4) begin
                chk("bp_ovf0_before", 32'(overflow[0]), 0);
            end
        end
        idle_inputs();
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_data",  32'(out_data), 32'h01);
        chk("bp_ovf0",  32'(overflow[0]), 1);
        chk("bp_ovf1",  32'(overflow[1]), 0);
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            if (j < 4) begin
                chk("bp_drain_valid", 32'(out_valid), 1);
                chk("bp_drain_data",  32'(out_data), 32'(j + 2));
            end else begin
                chk("bp_drain_end", 32'(out_valid), 0);
            end
        end
        chk("bp_ovf0_sticky", 32'(overflow[0]), 1);

        // ---------------- full FIFO popped while written ----------------
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid[1] = 1'b1;
            in_data[1]  = 8'(8'h31 + k);
            tick();
        end
        chk("fp_hold_data", 32'(out_data), 32'h31);
        out_ready   = 1'b1;
        in_valid[1] = 1'b1;
        in_data[1]  = 8'h36;
        tick();
        idle_inputs();
        chk("fp_ovf1", 32'(overflow[1]), 0);
        for (int j = 0; j < 5; j++) begin
            chk("fp_drain_data", 32'(out_data), 32'(8'h32 + j));
            chk("fp_drain_lane", 32'(out_lane), 1);
            tick();
        end
        chk("fp_drain_end", 32'(out_valid), 0);

        // ---------------- reset mid-stream ----------------
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid[0] = (k < 4);
            in_data[0]  = 8'(8'h41 + k);
            in_valid[1] = 1'b1;
            in_data[1]  = 8'(8'h51 + k);
            tick();
        end
        idle_inputs();
        chk("mr_pre_valid", 32'(out_valid), 1);
        chk("mr_pre_data",  32'(out_data), 32'h41);
        chk("mr_pre_ovf1",  32'(overflow[1]), 1);
        rst_n = 1'b0;
        #1;
        chk("mr_async_valid", 32'(out_valid), 0);
        chk("mr_async_data",  32'(out_data), 0);
        chk("mr_async_ovf1",  32'(overflow[1]), 0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("mr_no_stale", 32'(out_valid), 0);
        end

`ifdef ARRAY_BUS_MERGE_STATS_EN
        // ---------------- delivery counters ----------------
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 8'(k);
            in_valid[1] = (k < 2);
            in_data[1]  = 8'(k);
            tick();
        end
        idle_inputs();
        for (int j = 0; j < 6; j++) tick();
        chk("st_cnt0", 32'(delivered_cnt[0]), 3);
        chk("st_cnt1", 32'(delivered_cnt[1]), 2);
        for (int n = 0; n < 65532; n++) begin
            in_valid[0] = 1'b1;
            tick();
        end
        idle_inputs();
        for (int j = 0; j < 4; j++) tick();
        chk("st_cnt0_max", 32'(delivered_cnt[0]), 32'hFFFF);
        in_valid[0] = 1'b1;
        tick();
        idle_inputs();
        for (int j = 0; j < 4; j++) tick();
        chk("st_cnt0_wrap", 32'(delivered_cnt[0]), 0);
        chk("st_cnt1_keep", 32'(delivered_cnt[1]), 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/array_bus_merge.md
ARRAY_BUS_MERGE -- requirements
Module: array_bus_merge

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, lane data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, per-lane FIFO entries (power of two, >= 2).
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port in_data  input  [DATA_W-1:0] x [0:1] unpacked  per-lane data from the upstream two-lane registered array bus.
REQ-006 The block SHALL have port in_valid  input  1 x [0:1] unpacked  per-lane valid; no backpressure upstream.
REQ-007 The block SHALL have port out_data  output  DATA_W  merged word.
REQ-008 The block SHALL have port out_lane  output  1  source lane of out_data.
REQ-009 The block SHALL have port out_valid  output  1  merged word present.
REQ-010 The block SHALL have port out_ready  input  1  downstream accept.
REQ-011 The block SHALL have port overflow  output  1 x [0:1] unpacked  sticky per-lane drop flag.

Function
REQ-012 Lane i in cycle N with in_valid[i]=1 SHALL be written into FIFO i at edge N if FIFO i not full, or if full and popped in the same cycle.
REQ-013 A lane word arriving at a full FIFO not popped that cycle SHALL be dropped and overflow[i] set at that edge, held until reset.
REQ-014 Both lanes SHALL be writable in the same cycle, independently.
REQ-015 Output stage SHALL be a single register; it loads when out_valid=0 or (out_valid=1 and out_ready=1).
REQ-016 On load, arbiter SHALL pick among non-empty FIFOs: one non-empty -> that lane; both -> lane at round-robin pointer.
REQ-017 Pointer SHALL reset to lane 0 and, after granting lane i, point to lane 1-i.
REQ-018 While out_valid=1 and out_ready=0, out_data and out_lane SHALL hold stable.
REQ-019 If load condition holds and both FIFOs empty, out_valid SHALL go 0 next cycle.
REQ-020 Latency SHALL be 2 cycles: word on in_* in cycle N, FIFO and output register empty -> out_valid=1 in cycle N+2.
REQ-021 Sustained throughput SHALL be one word per cycle total; per-lane order SHALL be preserved.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH using a DEPTH+1 occupancy count (full = DEPTH, empty = 0).

Reset
REQ-023 rst_n low SHALL immediately force out_valid=0, out_data=0, out_lane=0, overflow=0, both FIFOs empty, pointer=lane 0.
REQ-024 Reset mid-operation SHALL discard all buffered and presented words; no word SHALL emerge after release that was accepted before assertion.

Configuration
REQ-025 With ARRAY_BUS_MERGE_STATS_EN defined, block SHALL add output delivered_cnt  16 x [0:1] unpacked, incremented per out_valid&&out_ready handshake for the word's lane, wrapping 0xFFFF->0, reset to 0.
REQ-026 Without ARRAY_BUS_MERGE_STATS_EN, port and counters SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package array_bus_pkg SHALL hold NUM_LANES=2, DATA_W default, lane index typedef and data word typedef, shared with the upstream array-bus stage.
REQ-028 Per-lane FIFO SHALL be sub-module array_bus_lane_fifo (push, pop, data, full, empty), instantiated twice.

Verification
REQ-029 Single word: in_valid[0]=1, in_data[0]=0x5A one cycle, out_ready=1 -> out_valid=1, out_data=0x5A, out_lane=0 exactly 2 cycles later, one cycle only.
REQ-030 Contention: both lanes valid 4 cycles, lane0 0x10..0x13, lane1 0x20..0x23, out_ready=1 -> output 0x10,0x20,0x11,0x21,... alternating, 8 words, no overflow.
REQ-031 Backpressure/overflow: out_ready=0, lane0 valid 6 cycles 0x01..0x06, DEPTH=4 -> output holds 0x01, FIFO takes 0x02..0x05, 0x06 dropped, overflow[0]=1, overflow[1]=0; release -> 0x01..0x05.
REQ-032 Full-with-pop: lane1 FIFO full, out_ready=1 granting lane1 while in_valid[1]=1 -> word accepted, overflow[1] stays 0.
REQ-033 Reset mid-stream: rst_n low with 3 words buffered -> out_valid=0 immediately; after release, no stale words; overflow=0.
REQ-034 With ARRAY_BUS_MERGE_STATS_EN: 3 lane0 and 2 lane1 handshakes -> delivered_cnt = {3,2}; preset 0xFFFF +1 -> 0.
